// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback FFT stage: one complex sample per valid
// cycle in and out, DELAY-deep feedback line, optional /2 scaling per butterfly.
module sdf_r2_stage #(
  parameter int SIGN_BIT = 1,
  parameter int INT_BIT  = 3,
  parameter int FR_BIT   = 6,
  parameter int DELAY    = 64,
  parameter int SCALE    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                din_vld,
  input  logic [SIGN_BIT+INT_BIT+FR_BIT-1:0]  din_re,
  input  logic [SIGN_BIT+INT_BIT+FR_BIT-1:0]  din_im,
  output logic [SIGN_BIT+INT_BIT+FR_BIT-1:0]  dout_re,
  output logic [SIGN_BIT+INT_BIT+FR_BIT-1:0]  dout_im,
  output logic                                dout_vld,
  output logic                                stop,
  output logic                                err
);

  localparam int DW = SIGN_BIT + INT_BIT + FR_BIT;
  localparam int AW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int CW = $clog2(DELAY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BFLY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   ptr_r;
  logic [AW-1:0]   ptr_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   pend_r;
  logic [DW-1:0]   mem_re_r [DELAY];
  logic [DW-1:0]   mem_im_r [DELAY];
  logic [DW-1:0]   line_re_s;
  logic [DW-1:0]   line_im_s;
  logic [DW:0]     sum_re_s;
  logic [DW:0]     sum_im_s;
  logic [DW:0]     diff_re_s;
  logic [DW:0]     diff_im_s;
  logic [DW-1:0]   wr_re_s;
  logic [DW-1:0]   wr_im_s;
  logic            we_s;
  logic            step_s;
  logic            fill_done_s;
  logic            pend_last_s;
  logic [DW-1:0]   dout_re_r;
  logic [DW-1:0]   dout_im_r;
  logic            dout_vld_r;
  logic            stop_r;
  logic            err_r;

  // Reduce a DW+1 bit butterfly result to DW bits: rounded halving or saturation.
  function automatic logic [DW-1:0] fold(input logic [DW:0] v);
    logic signed [DW:0] r;
    r = $signed(v) + $signed((DW+1)'(1));
    if (SCALE != 0) begin
      fold = DW'(r >>> 1);
    end else if (v[DW] != v[DW-1]) begin
      fold = v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      fold = v[DW-1:0];
    end
  endfunction

  assign line_re_s   = mem_re_r[ptr_r];
  assign line_im_s   = mem_im_r[ptr_r];
  assign sum_re_s    = {line_re_s[DW-1], line_re_s} + {din_re[DW-1], din_re};
  assign sum_im_s    = {line_im_s[DW-1], line_im_s} + {din_im[DW-1], din_im};
  assign diff_re_s   = {line_re_s[DW-1], line_re_s} - {din_re[DW-1], din_re};
  assign diff_im_s   = {line_im_s[DW-1], line_im_s} - {din_im[DW-1], din_im};
  assign ptr_nxt_s   = (ptr_r == AW'(DELAY - 1)) ? {AW{1'b0}} : ptr_r + AW'(1);
  assign fill_done_s = (cnt_r == CW'(DELAY - 1));
  assign pend_last_s = (pend_r == CW'(1));

  // Decide whether this cycle advances the line and what gets written back.
  always_comb begin
    step_s  = 1'b0;
    we_s    = 1'b0;
    wr_re_s = din_re;
    wr_im_s = din_im;
    case (state_r)
      IDLE: begin
        step_s = din_vld & start;
        we_s   = din_vld & start;
      end
      FILL: begin
        step_s = din_vld;
        we_s   = din_vld;
      end
      BFLY: begin
        step_s  = din_vld;
        we_s    = din_vld;
        wr_re_s = fold(diff_re_s);
        wr_im_s = fold(diff_im_s);
      end
      DRAIN: begin
        step_s = 1'b1;
        we_s   = din_vld & start;
      end
      default: begin
        step_s = 1'b0;
        we_s   = 1'b0;
      end
    endcase
  end

  // Feedback line storage; contents survive reset and are always written before read.
  always_ff @(posedge clk) begin
    if (we_s && !rst) begin
      mem_re_r[ptr_r] <= wr_re_s;
      mem_im_r[ptr_r] <= wr_im_s;
    end
  end

  // Stage control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= {AW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      pend_r     <= {CW{1'b0}};
      dout_re_r  <= {DW{1'b0}};
      dout_im_r  <= {DW{1'b0}};
      dout_vld_r <= 1'b0;
      stop_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      dout_vld_r <= 1'b0;
      stop_r     <= 1'b0;
      if (step_s) begin
        ptr_r <= ptr_nxt_s;
      end
      case (state_r)
        IDLE: begin
          if (din_vld && start) begin
            state_r <= fill_done_s ? BFLY : FILL;
            cnt_r   <= fill_done_s ? {CW{1'b0}} : cnt_r + CW'(1);
          end
        end
        FILL: begin
          if (din_vld) begin
            err_r <= err_r | start;
            // Leftover differences of the previous frame ride along with new inputs.
            if (pend_r != {CW{1'b0}}) begin
              dout_re_r  <= line_re_s;
              dout_im_r  <= line_im_s;
              dout_vld_r <= 1'b1;
              stop_r     <= pend_last_s;
              pend_r     <= pend_r - CW'(1);
            end
            state_r <= fill_done_s ? BFLY : FILL;
            cnt_r   <= fill_done_s ? {CW{1'b0}} : cnt_r + CW'(1);
          end
        end
        BFLY: begin
          if (din_vld) begin
            err_r      <= err_r | start;
            dout_re_r  <= fold(sum_re_s);
            dout_im_r  <= fold(sum_im_s);
            dout_vld_r <= 1'b1;
            if (fill_done_s) begin
              state_r <= DRAIN;
              cnt_r   <= {CW{1'b0}};
              pend_r  <= CW'(DELAY);
            end else begin
              cnt_r   <= cnt_r + CW'(1);
            end
          end
        end
        DRAIN: begin
          dout_re_r  <= line_re_s;
          dout_im_r  <= line_im_s;
          dout_vld_r <= 1'b1;
          stop_r     <= pend_last_s;
          pend_r     <= pend_r - CW'(1);
          if (din_vld && start) begin
            state_r <= fill_done_s ? BFLY : FILL;
            cnt_r   <= fill_done_s ? {CW{1'b0}} : cnt_r + CW'(1);
          end else begin
            if (din_vld) begin
              err_r <= 1'b1;
            end
            if (pend_last_s) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign dout_re  = dout_re_r;
  assign dout_im  = dout_im_r;
  assign dout_vld = dout_vld_r;
  assign stop     = stop_r;
  assign err      = err_r;

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Bench for sdf_r2_stage (DW=10, DELAY=4): SCALE=0 and SCALE=1 instances share
// stimulus and are compared cycle by cycle against a frame-level reference.
module tb_sdf_r2_stage;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       din_vld;
  logic [9:0] din_re;
  logic [9:0] din_im;
  logic [9:0] d0_re, d0_im, d1_re, d1_im;
  logic       v0, v1, s0, s1, e0, e1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: current frame inputs and queue of unsent differences.
  bit in_frame;
  int n_in;
  int fx_re [2*D];
  int fx_im [2*D];
  int dq_re [$];
  int dq_im [$];
  bit m_err;
  bit exp_vld, exp_stop, chk_data;
  int exp_raw_re, exp_raw_im;

  sdf_r2_stage #(.SIGN_BIT(1), .INT_BIT(3), .FR_BIT(6), .DELAY(D), .SCALE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start), .din_vld(din_vld),
    .din_re(din_re), .din_im(din_im),
    .dout_re(d0_re), .dout_im(d0_im), .dout_vld(v0), .stop(s0), .err(e0)
  );

  sdf_r2_stage #(.SIGN_BIT(1), .INT_BIT(3), .FR_BIT(6), .DELAY(D), .SCALE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start), .din_vld(din_vld),
    .din_re(din_re), .din_im(din_im),
    .dout_re(d1_re), .dout_im(d1_im), .dout_vld(v1), .stop(s1), .err(e1)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  function automatic int half(input int v);
    return (v + 1) >>> 1;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(1023, 0)) - 512;
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic emit_diff();
    exp_vld    = 1'b1;
    chk_data   = 1'b1;
    exp_raw_re = dq_re.pop_front();
    exp_raw_im = dq_im.pop_front();
    exp_stop   = (dq_re.size() == 0);
  endtask

  // Frame-level reference: sums of x[k]+x[k+D] as the second half arrives,
  // differences x[k]-x[k+D] one per later step (drain cycle or next-frame input).
  task automatic model(input bit r, input bit s, input bit v, input int xr, input int xi);
    bit draining;
    exp_vld  = 1'b0;
    exp_stop = 1'b0;
    chk_data = 1'b0;
    if (r) begin
      in_frame = 1'b0;
      n_in     = 0;
      dq_re.delete();
      dq_im.delete();
      m_err      = 1'b0;
      chk_data   = 1'b1;
      exp_raw_re = 0;
      exp_raw_im = 0;
    end else if (in_frame) begin
      if (v) begin
        if (s) m_err = 1'b1;
        fx_re[n_in] = xr;
        fx_im[n_in] = xi;
        if (n_in >= D) begin
          exp_vld    = 1'b1;
          chk_data   = 1'b1;
          exp_raw_re = fx_re[n_in-D] + xr;
          exp_raw_im = fx_im[n_in-D] + xi;
          dq_re.push_back(fx_re[n_in-D] - xr);
          dq_im.push_back(fx_im[n_in-D] - xi);
        end else if (dq_re.size() > 0) begin
          emit_diff();
        end
        n_in++;
        if (n_in == 2*D) in_frame = 1'b0;
      end
    end else begin
      draining = (dq_re.size() > 0);
      if (draining) emit_diff();
      if (v && s) begin
        in_frame = 1'b1;
        fx_re[0] = xr;
        fx_im[0] = xi;
        n_in     = 1;
      end else if (v && draining) begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit v, input int xr, input int xi);
    rst     = r;
    start   = s;
    din_vld = v;
    din_re  = 10'(xr);
    din_im  = 10'(xi);
    model(r, s, v, sat(xr + 1024) == 0 ? xr : $signed(10'(xr)), $signed(10'(xi)));
    @(posedge clk);
    #1;
    chk("vld_sc0", 10'(v0), 10'(exp_vld));
    chk("vld_sc1", 10'(v1), 10'(exp_vld));
    chk("stop_sc0", 10'(s0), 10'(exp_stop));
    chk("stop_sc1", 10'(s1), 10'(exp_stop));
    chk("err_sc0", 10'(e0), 10'(m_err));
    chk("err_sc1", 10'(e1), 10'(m_err));
    if (chk_data) begin
      chk("re_sc0", d0_re, 10'(sat(exp_raw_re)));
      chk("im_sc0", d0_im, 10'(sat(exp_raw_im)));
      chk("re_sc1", d1_re, 10'(half(exp_raw_re)));
      chk("im_sc1", d1_im, 10'(half(exp_raw_im)));
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, rnd(), rnd());
  endtask

  initial begin
    // 1: reset held with random inputs
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), rnd(), rnd());
    idle(2);

    // 2: ramp 1..8 on consecutive cycles, then drain
    for (int i = 0; i < 2*D; i++) step(1'b0, i == 0, 1'b1, i + 1, 0);
    idle(6);

    // 3: saturation and rounding corner pairs
    step(1'b0, 1'b1, 1'b1,  511,  511);
    step(1'b0, 1'b0, 1'b1, -512, -512);
    step(1'b0, 1'b0, 1'b1,    3,    3);
    step(1'b0, 1'b0, 1'b1, rnd(), rnd());
    step(1'b0, 1'b0, 1'b1,  511,  511);
    step(1'b0, 1'b0, 1'b1, -512, -512);
    step(1'b0, 1'b0, 1'b1,    0,    0);
    step(1'b0, 1'b0, 1'b1, rnd(), rnd());
    idle(5);

    // 4: back-to-back frames, second start after two drain cycles
    for (int i = 0; i < 2*D; i++) step(1'b0, i == 0, 1'b1, rnd(), rnd());
    idle(2);
    for (int i = 0; i < 2*D; i++) step(1'b0, i == 0, 1'b1, rnd(), rnd());
    idle(6);

    // 5: reset at the second butterfly input, then a clean ramp frame
    for (int i = 0; i < D + 1; i++) step(1'b0, i == 0, 1'b1, rnd(), rnd());
    step(1'b1, 1'b0, 1'b1, rnd(), rnd());
    idle(2);
    for (int i = 0; i < 2*D; i++) step(1'b0, i == 0, 1'b1, i + 1, 0);
    idle(6);

    // 6: stray valid in idle, start during butterfly, stray valid in drain
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, rnd(), rnd());
    for (int i = 0; i < 2*D; i++) step(1'b0, (i == 0) || (i == D + 2), 1'b1, rnd(), rnd());
    step(1'b0, 1'b0, 1'b0, rnd(), rnd());
    step(1'b0, 1'b0, 1'b1, rnd(), rnd());
    idle(5);
    step(1'b1, 1'b0, 1'b0, rnd(), rnd());
    idle(2);

    // Random traffic: gaps, overlapping frames, protocol errors, occasional reset
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99, 0) < 2, $urandom_range(99, 0) < 12,
           $urandom_range(99, 0) < 75, rnd(), rnd());
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
